display_scan_ctrl: RTL and testbench

- Sequential front end that drives the hex/mode 7-segment display decoder.
- Generates the digit-select scan (upper nibble, lower nibble, mode glyph) with anti-ghosting blanking.
- Debounces the mode push-button and toggles receive/transmit mode.
- Latches the last received UART byte and presents it, or the next transmit byte, as the displayed byte, updating only at frame boundaries to avoid tearing.

---
 rtl/display_pkg.sv | 18 +
 rtl/button_debounce.sv | 44 ++++
 rtl/display_scan_ctrl.sv | 103 ++++++++++
 tb/tb_display_scan_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared encodings for the display scan front end and the 7-segment decoder.
package display_pkg;

  // Digit-select codes driven on the scan 'array' output.
  typedef enum logic [1:0] {
    SLOT_UPPER = 2'd0,
    SLOT_LOWER = 2'd1,
    SLOT_MODE  = 2'd2,
    SLOT_BLANK = 2'd3
  } slot_e;

  // Displayed mode glyph: receive ("r") or transmit ("S").
  typedef enum logic {
    MODE_RX = 1'b0,
    MODE_TX = 1'b1
  } mode_e;

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a
// one-cycle pulse on each accepted press (release is accepted silently).
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic          stable;
  logic [CW-1:0] cnt;

  // Synchronize, then accept a new level only after it has held long enough.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      stable <= 1'b0;
      press  <= 1'b0;
      cnt    <= '0;
    end else begin
      meta  <= btn;
      sync  <= meta;
      press <= 1'b0;
      if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync;
        press  <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Display scan front end: digit multiplexing with blanking, mode toggle from
// a debounced button, and frame-aligned update of the displayed byte/mode.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES    = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       mode_btn,
  output logic       mode,
  output logic [7:0] data,
  output logic [1:0] array,
  output logic       frame_tick
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  slot_e         slot;
  slot_e         slot_nxt;
  logic          wrap;
  logic          commit;
  logic          mode_pending;
  logic [7:0]    rx_shadow;
  logic          press;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_mode_btn (
    .clk  (clk),
    .reset(reset),
    .btn  (mode_btn),
    .press(press)
  );

  // Next scan position; commit fires on the wrap out of the mode-glyph slot.
  always_comb begin
    wrap     = (cnt == CNT_LAST);
    cnt_nxt  = wrap ? '0 : cnt + 1'b1;
    slot_nxt = slot;
    if (wrap) begin
      case (slot)
        SLOT_UPPER: slot_nxt = SLOT_LOWER;
        SLOT_LOWER: slot_nxt = SLOT_MODE;
        default:    slot_nxt = SLOT_UPPER;
      endcase
    end
    commit = wrap && (slot == SLOT_MODE);
  end

  // Scan counters; array is registered from next-state values so it has no lag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      slot       <= SLOT_UPPER;
      array      <= SLOT_BLANK;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      slot       <= slot_nxt;
      array      <= (cnt_nxt < BLANK_LIM) ? SLOT_BLANK : slot_nxt;
      frame_tick <= commit;
    end
  end

  // Track pending mode and last rx byte; publish both only at frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_pending <= 1'b0;
      rx_shadow    <= '0;
      mode         <= 1'b0;
      data         <= '0;
    end else begin
      if (press) begin
        mode_pending <= ~mode_pending;
      end
      if (rx_valid) begin
        rx_shadow <= rx_data;
      end
      if (commit) begin
        mode <= mode_pending;
        if (mode_pending == MODE_TX) begin
          data <= tx_data;
        end else if (rx_valid) begin
          // same-cycle byte bypasses the shadow so it is not a frame late
          data <= rx_data;
        end else begin
          data <= rx_shadow;
        end
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl with a small refresh/debounce setup.
module tb_display_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       mode_btn = 1'b0;
  logic       mode;
  logic [7:0] data;
  logic [1:0] array;
  logic       frame_tick;

  display_scan_ctrl #(
    .REFRESH_DIV    (8),
    .BLANK_CYCLES   (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .mode_btn  (mode_btn),
    .mode      (mode),
    .data      (data),
    .array     (array),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Cycle index since the most recent reset release (cycle 0 = first cycle).
  int unsigned cyc = 0;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    int unsigned cyc;
    logic [7:0]  data;
    logic        mode;
  } frame_t;

  frame_t     frame_q[$];
  logic [1:0] arr_q[$];
  frame_t     fexp;
  logic [7:0] prev_data = 8'h00;
  logic       prev_mode = 1'b0;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic exp_frame(input int unsigned c, input logic [7:0] d, input logic m);
    frame_t f;
    f.cyc  = c;
    f.data = d;
    f.mode = m;
    frame_q.push_back(f);
  endtask

  task automatic push_scan(input int unsigned frames);
    for (int unsigned f = 0; f < frames; f++)
      for (int unsigned s = 0; s < 3; s++)
        for (int unsigned c = 0; c < 8; c++)
          arr_q.push_back((c < 2) ? 2'd3 : 2'(s));
  endtask

  task automatic wait_cyc(input int unsigned k);
    int unsigned g = 0;
    while (cyc < k) begin
      @(posedge clk);
      #1;
      g++;
      if (g > 2000) begin
        $display("FAIL wait_cyc: stuck at cycle %0d, target %0d", cyc, k);
        $fatal(1);
      end
    end
  endtask

  task automatic hold_btn(input int unsigned n);
    mode_btn = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    mode_btn = 1'b0;
  endtask

  // Monitor: scan pattern per cycle, frame values on each frame_tick, and
  // no change of data/mode between frame starts.
  always @(negedge clk) begin
    if (reset) begin
      prev_data = 8'h00;
      prev_mode = 1'b0;
    end else begin
      if (arr_q.size() > 0) check("array_scan", 32'(array), 32'(arr_q.pop_front()));
      if (frame_tick) begin
        if (frame_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_frame_tick: got tick at cycle %0d expected none", cyc);
        end else begin
          fexp = frame_q.pop_front();
          check("tick_cycle", cyc, fexp.cyc);
          check("tick_data", 32'(data), 32'(fexp.data));
          check("tick_mode", 32'(mode), 32'(fexp.mode));
        end
      end else begin
        check("data_hold", 32'(data), 32'(prev_data));
        check("mode_hold", 32'(mode), 32'(prev_mode));
      end
      prev_data = data;
      prev_mode = mode;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [9:0] bounce;
    bounce = 10'b1101001011;

    // Reset state while reset is held.
    repeat (3) @(posedge clk);
    #1;
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_data", 32'(data), 32'h00);
    check("rst_array", 32'(array), 32'd3);
    check("rst_tick", 32'(frame_tick), 32'd0);

    push_scan(2);
    exp_frame(24,  8'hA5, 1'b0);
    exp_frame(48,  8'hA5, 1'b0);
    exp_frame(72,  8'h3C, 1'b1);
    exp_frame(96,  8'hA5, 1'b0);
    exp_frame(120, 8'h7E, 1'b0);
    exp_frame(144, 8'h3C, 1'b1);
    reset = 1'b0;

    // rx byte in slot 1 of the first frame; shown only from the next frame.
    wait_cyc(10);
    rx_data = 8'hA5; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_data = 8'h00;
    wait_cyc(20);
    check("data_before_commit", 32'(data), 32'h00);

    // Bouncy press then a solid hold: one toggle into transmit mode.
    wait_cyc(49);
    tx_data = 8'h3C;
    for (int unsigned i = 0; i < 10; i++) begin
      mode_btn = bounce[i];
      @(posedge clk); #1;
    end
    hold_btn(10);

    // Second press returns to receive mode; shadow A5 reappears.
    wait_cyc(78);
    hold_btn(10);

    // rx byte in the last cycle of slot 2 goes straight to the display.
    wait_cyc(119);
    rx_data = 8'h7E; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_data = 8'h00;

    // Back to transmit mode, then reset in the middle of slot 1.
    wait_cyc(122);
    hold_btn(10);
    wait_cyc(154);
    check("pre_reset_mode", 32'(mode), 32'd1);
    check("pre_reset_data", 32'(data), 32'h3C);
    check("frames_consumed", frame_q.size(), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_array", 32'(array), 32'd3);
    check("async_rst_data", 32'(data), 32'h00);
    check("async_rst_mode", 32'(mode), 32'd0);
    push_scan(1);
    exp_frame(24, 8'h00, 1'b0);
    exp_frame(48, 8'h00, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Short glitch must not be accepted as a press.
    wait_cyc(3);
    hold_btn(3);

    wait_cyc(52);
    check("frames_left", frame_q.size(), 32'd0);
    check("scan_left", arr_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
